// File: rtl/burst_loader_if.sv
// Fabric-side bus of burst_loader: arbitration, address phase and data beats.
interface burst_loader_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic            REQUEST;
    logic            EN;
    logic            REQUEST_OK;
    logic            ADDRFD;
    logic            WRITEFD;
    logic            READFD;
    logic [4*AW-1:0] FD_ADDR;
    logic [DW-1:0]   FD_OUT;
    logic [DW-1:0]   FD_IN;
    logic            SLAVE_ACK;
    logic            FD_READY;
    logic            FD_VALID;

    // The loader masters the bus; the fabric (arbiter + slave) is the other side.
    modport master (
        output REQUEST, ADDRFD, WRITEFD, READFD, FD_ADDR, FD_OUT,
        input  EN, REQUEST_OK, FD_IN, SLAVE_ACK, FD_READY, FD_VALID
    );
    modport slave (
        input  REQUEST, ADDRFD, WRITEFD, READFD, FD_ADDR, FD_OUT,
        output EN, REQUEST_OK, FD_IN, SLAVE_ACK, FD_READY, FD_VALID
    );
endinterface

// File: rtl/burst_loader.sv
// Burst loader: moves BURST-word blocks between a local L1 buffer, the fabric
// and the command port. WRITE = L1 -> fabric, READ = fabric -> L1,
// LOAD = fabric -> command port. Every output is decoded from registers only.
module burst_loader #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 255,
    parameter int N       = 1
) (
    input  logic                     CLK_B,
    input  logic                     RESET,
    input  logic                     WRITE,
    input  logic                     READ,
    input  logic                     LOAD,
    input  logic [AW-1:0]            SA,
    input  logic [AW-1:0]            SB,
    input  logic [AW-1:0]            SC,
    input  logic [AW-1:0]            IP,
    output logic                     store_busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(BURST)-1:0] L1ADR,
    output logic                     L1RD,
    output logic                     L1WR,
    input  logic [DW-1:0]            L1DIN,
    output logic [DW-1:0]            L1DOUT,
    output logic                     CMD_WE,
    output logic [$clog2(BURST)-1:0] CMD_ADR,
    output logic [DW-1:0]            CMD_DAT,
    output logic [3:0]               NUMBER_UNIT,
    burst_loader_if.master           fab
);
    localparam int CW  = $clog2(BURST);
    localparam int WW  = $clog2(TIMEOUT + 1);
    localparam int BM1 = BURST - 1;
    localparam int TM1 = TIMEOUT - 1;

    localparam logic [CW:0]   FILL_LAST = BURST[CW:0];
    localparam logic [CW-1:0] LAST_IDX  = BM1[CW-1:0];
    localparam logic [WW-1:0] WAIT_LAST = TM1[WW-1:0];

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_ARB    = 3'd2;
    localparam logic [2:0] S_ADDR   = 3'd3;
    localparam logic [2:0] S_WBURST = 3'd4;
    localparam logic [2:0] S_RBURST = 3'd5;
    localparam logic [2:0] S_DRAIN  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [1:0] M_NONE  = 2'd0;
    localparam logic [1:0] M_WRITE = 2'd1;
    localparam logic [1:0] M_READ  = 2'd2;
    localparam logic [1:0] M_LOAD  = 2'd3;

    logic [2:0]      state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [4*AW-1:0] addr_q, addr_d;
    logic [CW:0]     cnt_q, cnt_d;      // FILL cycle / DRAIN word index
    logic [CW-1:0]   beat_q, beat_d;    // fabric beat index
    logic [WW-1:0]   wait_q, wait_d;    // stall cycles since last progress
    logic            err_q, err_d;
    logic            stall;

    logic [DW-1:0]   buf_q [BURST];
    logic            buf_we;
    logic [CW-1:0]   buf_wa;
    logic [DW-1:0]   buf_wd;

    // Next-state, buffer write port and stall timeout.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d = state_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        buf_we  = 1'b0;
        buf_wa  = '0;
        buf_wd  = '0;
        case (state_q)
            S_IDLE: begin
                if (WRITE || READ || LOAD) begin
                    addr_d = {SA, SB, SC, IP};
                    cnt_d  = '0;
                    if (WRITE) begin
                        mode_d  = M_WRITE;
                        state_d = S_FILL;
                    end else begin
                        mode_d  = READ ? M_READ : M_LOAD;
                        state_d = S_ARB;
                    end
                end
            end
            S_FILL: begin
                // L1 read data trails its address by one cycle.
                if (cnt_q != '0) begin
                    buf_we = 1'b1;
                    buf_wa = cnt_q[CW-1:0] - 1'b1;
                    buf_wd = L1DIN;
                end
                if (cnt_q == FILL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ARB: begin
                if (fab.EN && fab.REQUEST_OK) begin
                    wait_d  = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (fab.SLAVE_ACK) begin
                    wait_d  = '0;
                    beat_d  = '0;
                    state_d = (mode_q == M_WRITE) ? S_WBURST : S_RBURST;
                end else begin
                    stall = 1'b1;
                end
            end
            S_WBURST: begin
                if (fab.FD_READY) begin
                    wait_d = '0;
                    if (beat_q == LAST_IDX) state_d = S_DONE;
                    else                    beat_d  = beat_q + 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            S_RBURST: begin
                if (fab.FD_VALID) begin
                    wait_d = '0;
                    buf_we = 1'b1;
                    buf_wa = beat_q;
                    buf_wd = fab.FD_IN;
                    if (beat_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q[CW-1:0] == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                mode_d  = M_NONE;
                beat_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A stalled fabric phase that hits the limit abandons the transfer.
        if (stall) begin
            if (wait_q == WAIT_LAST) begin
                err_d   = 1'b1;
                mode_d  = M_NONE;
                beat_d  = '0;
                wait_d  = '0;
                state_d = S_IDLE;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge CLK_B) begin
        if (RESET) begin
            state_q <= S_IDLE;
            mode_q  <= M_NONE;
            addr_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Burst buffer storage.
    // NOTE: no reset on the buffer; every word is written before it is read.
    always_ff @(posedge CLK_B) begin
        if (buf_we) buf_q[buf_wa] <= buf_wd;
    end

    assign NUMBER_UNIT = N[3:0];
    assign store_busy  = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;

    assign L1RD    = (state_q == S_FILL) && (cnt_q != FILL_LAST);
    assign L1WR    = (state_q == S_DRAIN) && (mode_q == M_READ);
    assign CMD_WE  = (state_q == S_DRAIN) && (mode_q == M_LOAD);
    assign L1ADR   = (L1RD || L1WR) ? cnt_q[CW-1:0] : '0;
    assign L1DOUT  = L1WR ? buf_q[cnt_q[CW-1:0]] : '0;
    assign CMD_ADR = CMD_WE ? cnt_q[CW-1:0] : '0;
    assign CMD_DAT = CMD_WE ? buf_q[cnt_q[CW-1:0]] : '0;

    assign fab.REQUEST = (state_q == S_ARB);
    assign fab.ADDRFD  = (state_q == S_ADDR);
    assign fab.WRITEFD = (state_q == S_WBURST);
    assign fab.READFD  = (state_q == S_RBURST);
    assign fab.FD_ADDR = fab.ADDRFD ? addr_q : '0;
    assign fab.FD_OUT  = fab.WRITEFD ? buf_q[beat_q] : '0;
endmodule
